pool_engine: RTL

Parametrised max-pooling engine for the LeNet datapath. It sits between the convolution output SRAM and the next layer's input SRAM. On a start pulse it reads `number_feature` square activation maps of side `size_act`. Each map is reduced with a non-overlapping `size_kernel` × `size_kernel` max window, stride equal to kernel. The pooled results are written back, one word per output pixel, and a one-cycle `done` pulse is raised at the end.

---
 rtl/pool_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pool_engine.sv
// Max-pooling engine: non-overlapping KxK windows over N square maps, one pooled word written per output pixel.
// Build option: define POOL_RELU_EN to clamp negative maxima to zero on the write.
module pool_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        size_act,
    input  logic [3:0]        size_kernel,
    input  logic [7:0]        number_feature,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_WRITE, S_NEXT, S_FINISH
    } state_t;

    state_t r_state, w_state_next;

    logic [7:0]        r_s, r_n, r_o;
    logic [3:0]        r_k;
    logic [ADDR_W-1:0] r_rd_base, r_wr_base, r_s_sq, r_o_sq;
    logic [3:0]        r_i, r_j;
    logic [7:0]        r_c, r_r, r_f;
    logic [1:0]        r_drain;
    logic [RD_LAT-1:0] r_vld, r_first;
    logic [DATA_W-1:0] r_max, r_wr_data;
    logic [ADDR_W-1:0] r_wr_addr;

    logic [7:0]        w_o;
    logic              w_i_last, w_j_last, w_c_last, w_r_last, w_f_last;
    logic              w_bad_cfg, w_rd_en, w_first;
    logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
    logic [DATA_W-1:0] w_max_next, w_wr_val;

    assign w_o       = (r_k == 4'd0) ? 8'd0 : r_s / {4'd0, r_k};
    assign w_bad_cfg = (r_k == 4'd0) || ({4'd0, r_k} > r_s) || (r_n == 8'd0);
    assign w_i_last  = (r_i == r_k - 4'd1);
    assign w_j_last  = (r_j == r_k - 4'd1);
    assign w_c_last  = (r_c == r_o - 8'd1);
    assign w_r_last  = (r_r == r_o - 8'd1);
    assign w_f_last  = (r_f == r_n - 8'd1);
    assign w_rd_en   = (r_state == S_ISSUE);
    assign w_first   = (r_i == 4'd0) && (r_j == 4'd0);

    assign w_rd_addr = r_rd_base + ADDR_W'(r_f) * r_s_sq
                     + (ADDR_W'(r_r) * ADDR_W'(r_k) + ADDR_W'(r_i)) * ADDR_W'(r_s)
                     + ADDR_W'(r_c) * ADDR_W'(r_k) + ADDR_W'(r_j);
    assign w_wr_addr = r_wr_base + ADDR_W'(r_f) * r_o_sq
                     + ADDR_W'(r_r) * ADDR_W'(r_o) + ADDR_W'(r_c);

    // Running max sees the word returning this cycle so the final window word lands in the write.
    always_comb begin
        w_max_next = r_max;
        if (r_vld[RD_LAT-1]) begin
            if (r_first[RD_LAT-1] || ($signed(rd_data) > $signed(r_max)))
                w_max_next = rd_data;
        end
    end

`ifdef POOL_RELU_EN
    assign w_wr_val = w_max_next[DATA_W-1] ? '0 : w_max_next;
`else
    assign w_wr_val = w_max_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_LOAD;
            S_LOAD:   w_state_next = w_bad_cfg ? S_FINISH : S_ISSUE;
            S_ISSUE:  if (w_i_last && w_j_last) w_state_next = S_DRAIN;
            S_DRAIN:  if (r_drain == 2'd0) w_state_next = S_WRITE;
            S_WRITE:  w_state_next = S_NEXT;
            S_NEXT:   w_state_next = (w_c_last && w_r_last && w_f_last) ? S_FINISH : S_ISSUE;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= '0; r_k <= '0; r_n <= '0; r_o <= '0;
            r_rd_base <= '0; r_wr_base <= '0; r_s_sq <= '0; r_o_sq <= '0;
            r_i <= '0; r_j <= '0; r_c <= '0; r_r <= '0; r_f <= '0;
            r_drain <= '0; r_vld <= '0; r_first <= '0; r_max <= '0;
            r_wr_addr <= '0; r_wr_data <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_s <= size_act; r_k <= size_kernel; r_n <= number_feature;
                r_rd_base <= rd_base; r_wr_base <= wr_base;
            end
            if (r_state == S_LOAD) begin
                r_o    <= w_o;
                r_s_sq <= ADDR_W'(r_s) * ADDR_W'(r_s);
                r_o_sq <= ADDR_W'(w_o) * ADDR_W'(w_o);
                r_i <= '0; r_j <= '0; r_c <= '0; r_r <= '0; r_f <= '0;
            end
            if (r_state == S_ISSUE) begin
                r_drain <= 2'(RD_LAT - 1);
                if (w_j_last) begin
                    r_j <= '0;
                    r_i <= w_i_last ? 4'd0 : r_i + 4'd1;
                end else begin
                    r_j <= r_j + 4'd1;
                end
            end
            if (r_state == S_DRAIN) begin
                if (r_drain != 2'd0) begin
                    r_drain <= r_drain - 2'd1;
                end else begin
                    r_wr_addr <= w_wr_addr;
                    r_wr_data <= w_wr_val;
                end
            end
            if (r_state == S_NEXT) begin
                if (!w_c_last) begin
                    r_c <= r_c + 8'd1;
                end else begin
                    r_c <= '0;
                    if (!w_r_last) begin
                        r_r <= r_r + 8'd1;
                    end else begin
                        r_r <= '0;
                        r_f <= r_f + 8'd1;
                    end
                end
            end
            r_vld   <= RD_LAT'({r_vld, w_rd_en});
            r_first <= RD_LAT'({r_first, w_first});
            r_max   <= w_max_next;
        end
    end

    assign rd_en   = w_rd_en;
    assign rd_addr = w_rd_en ? w_rd_addr : '0;
    assign wr_en   = (r_state == S_WRITE);
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_FINISH);

endmodule
